// File: rtl/wb_tdm_audio_out.sv
// Wishbone-fed sample FIFO driving a multichannel TDM codec link.
// Frames are popped atomically: a frame is transmitted only if every channel's sample is buffered.
module wb_tdm_audio_out #(
    parameter int unsigned SAMPLE_W   = 24,
    parameter int unsigned SLOT_BITS  = 32,
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [3:0]  wb_adr_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        tdm_bclk,
    output logic        tdm_fsync,
    output logic        tdm_sdata
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = AW + 1;
    localparam int unsigned BW    = $clog2(SLOT_BITS);
    localparam int unsigned SW    = $clog2(CHANNELS);
    localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic                 ack_q, err_q, en_q, flush_q, push_q, uf_clr_q, uf_q;
    logic [31:0]          dat_q;
    logic [SAMPLE_W-1:0]  push_data_q;
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]     level_q;
    logic [SAMPLE_W-1:0]  mem [FIFO_DEPTH];

    logic [DW-1:0]        div_q, div_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [SW-1:0]        slot_q, slot_d;
    logic [SLOT_BITS-1:0] shreg_q, shreg_d, word;
    logic                 bclk_q, bclk_d, loaded_q, loaded_d, fvalid_q, fvalid_d;
    logic                 fsync_q, fsync_d, sdata_q, sdata_d;
    logic                 present, pop, uf_set, valid;

    logic        req, is_data, is_ctrl, is_stat, is_rsvd, full, empty, bad, wr_ok;
    logic [31:0] rdata;
    logic        unused_bits;

    assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};

    // A request is only accepted when the previous cycle did not terminate one.
    assign req     = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign is_data = (wb_adr_i[3:2] == 2'd0);
    assign is_ctrl = (wb_adr_i[3:2] == 2'd1);
    assign is_stat = (wb_adr_i[3:2] == 2'd2);
    assign is_rsvd = (wb_adr_i[3:2] == 2'd3);
    assign full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty   = (level_q == '0);
    assign bad     = is_rsvd | (is_data & wb_we_i & full);
    assign wr_ok   = req & ~bad & wb_we_i;

    always_comb begin
        rdata = '0;
        if (is_ctrl) begin
            rdata[0] = en_q;
        end else if (is_stat) begin
            rdata[15:0] = 16'(level_q);
            rdata[16]   = uf_q;
            rdata[17]   = full;
            rdata[18]   = empty;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
            en_q        <= 1'b0;
            flush_q     <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            uf_clr_q    <= 1'b0;
        end else begin
            ack_q    <= req & ~bad;
            err_q    <= req & bad;
            dat_q    <= (req & ~bad & ~wb_we_i) ? rdata : '0;
            flush_q  <= wr_ok & is_ctrl & wb_dat_i[1];
            push_q   <= wr_ok & is_data;
            uf_clr_q <= wr_ok & is_stat & wb_dat_i[16];
            if (wr_ok & is_ctrl) en_q <= wb_dat_i[0];
            if (wr_ok & is_data) push_data_q <= wb_dat_i[SAMPLE_W-1:0];
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign wb_dat_o  = dat_q;
    assign tdm_bclk  = bclk_q & en_q;
    assign tdm_fsync = fsync_q & en_q;
    assign tdm_sdata = sdata_q & en_q;

    // Serialiser: loaded_q marks that the bit at the current position is on the pins.
    always_comb begin
        div_d    = div_q;
        bclk_d   = bclk_q;
        bit_d    = bit_q;
        slot_d   = slot_q;
        loaded_d = loaded_q;
        fvalid_d = fvalid_q;
        fsync_d  = fsync_q;
        sdata_d  = sdata_q;
        shreg_d  = shreg_q;
        word     = '0;
        valid    = fvalid_q;
        present  = 1'b0;
        pop      = 1'b0;
        uf_set   = 1'b0;
        if (flush_q) begin
            div_d    = '0;
            bclk_d   = 1'b0;
            bit_d    = '0;
            slot_d   = '0;
            loaded_d = 1'b0;
            fvalid_d = 1'b0;
            fsync_d  = 1'b0;
            sdata_d  = 1'b0;
            shreg_d  = '0;
        end else if (en_q) begin
            if (!loaded_q) begin
                present  = 1'b1;
                loaded_d = 1'b1;
                div_d    = '0;
            end else if (div_q == DW'(CLK_DIV - 1)) begin
                div_d   = '0;
                bclk_d  = ~bclk_q;
                present = bclk_q;
            end else begin
                div_d = div_q + DW'(1);
            end
            if (present) begin
                fsync_d = (slot_q == '0) && (bit_q == '0);
                if (bit_q == '0) begin
                    if (slot_q == '0) begin
                        valid    = (level_q >= LVL_W'(CHANNELS));
                        fvalid_d = valid;
                        uf_set   = ~valid;
                    end
                    if (valid) begin
                        pop  = 1'b1;
                        word = SLOT_BITS'(mem[rd_ptr_q]) << (SLOT_BITS - SAMPLE_W);
                    end
                    sdata_d = word[SLOT_BITS-1];
                    shreg_d = word << 1;
                end else begin
                    sdata_d = shreg_q[SLOT_BITS-1];
                    shreg_d = shreg_q << 1;
                end
                if (bit_q == BW'(SLOT_BITS - 1)) begin
                    bit_d  = '0;
                    slot_d = (slot_q == SW'(CHANNELS - 1)) ? '0 : slot_q + SW'(1);
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            div_q    <= '0;
            bclk_q   <= 1'b0;
            bit_q    <= '0;
            slot_q   <= '0;
            loaded_q <= 1'b0;
            fvalid_q <= 1'b0;
            fsync_q  <= 1'b0;
            sdata_q  <= 1'b0;
            shreg_q  <= '0;
            uf_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            div_q    <= div_d;
            bclk_q   <= bclk_d;
            bit_q    <= bit_d;
            slot_q   <= slot_d;
            loaded_q <= loaded_d;
            fvalid_q <= fvalid_d;
            fsync_q  <= fsync_d;
            sdata_q  <= sdata_d;
            shreg_q  <= shreg_d;
            if (uf_set) uf_q <= 1'b1;
            else if (uf_clr_q) uf_q <= 1'b0;
            if (flush_q) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push_q) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
                if (push_q && !pop) level_q <= level_q + LVL_W'(1);
                else if (pop && !push_q) level_q <= level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push_q && !flush_q) mem[wr_ptr_q] <= push_data_q;
    end
endmodule

// File: doc/wb_tdm_audio_out.md
Name: wb_tdm_audio_out

Overview:
- Parametrised Wishbone B3 classic slave that buffers PCM samples written by the Nios CPU and serialises them onto a multichannel TDM codec link.
- Successor to the fixed 2-channel codec path: generalised in channel count, sample width, slot width and FIFO depth.
- Adds frame-atomic underflow handling and a sticky status register.
- Sits between the system's wb_* master port and the codec pins, in the codec clock domain.

Parameters:
- SAMPLE_W, 24: sample width in bits; must be ≤ SLOT_BITS.
- SLOT_BITS, 32: BCLK periods per TDM slot.
- CHANNELS, 8: slots per frame (2..16).
- FIFO_DEPTH, 64: sample FIFO entries; must be a power of 2 and ≥ CHANNELS.
- CLK_DIV, 4: clk_clk cycles per BCLK half-period (≥1).

Ports:
- clk_clk, input, 1: sole clock.
- reset_reset_n, input, 1: asynchronous, active-low reset.
- wb_cyc_i, input, 1: bus cycle.
- wb_stb_i, input, 1: strobe.
- wb_adr_i, input, 4: byte address; bits [3:2] select the register.
- wb_we_i, input, 1: write enable.
- wb_sel_i, input, 4: byte selects; ignored, all accesses are full-word.
- wb_dat_i, input, 32: write data.
- wb_dat_o, output, 32: read data.
- wb_ack_o, output, 1: normal termination.
- wb_err_o, output, 1: error termination.
- tdm_bclk, output, 1: bit clock.
- tdm_fsync, output, 1: frame sync.
- tdm_sdata, output, 1: serial data.

Behaviour:
- Reset: all outputs 0; FIFO empty; CTRL = 0; underflow flag = 0; all counters = 0.
- Register map:
  - 0x0 DATA (W): pushes wb_dat_i[SAMPLE_W-1:0]. Reads return 0.
  - 0x4 CTRL (R/W): bit0 ENABLE. bit1 FLUSH, write-1, self-clearing, always reads 0.
  - 0x8 STATUS (R): [15:0] fill level; bit16 UNDERFLOW (sticky); bit17 FULL; bit18 EMPTY. Writing 1 to bit16 clears UNDERFLOW.
  - 0xC: reserved. Any access returns err.
- Wishbone handshake:
  - When cyc&stb is high and no ack/err was issued the previous cycle, exactly one of ack/err pulses for one cycle on the next cycle. Single-cycle latency, no wait states.
  - wb_dat_o is valid with ack and is 0 otherwise.
  - A DATA write while FULL gives err, and the sample is dropped.
- FIFO:
  - Push happens on the ack cycle of a DATA write.
  - Simultaneous push and pop leave the level unchanged.
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap; the level is one bit wider.
- FLUSH:
  - Empties the FIFO in the cycle after the ack.
  - Aborts the current frame: counters return to 0, tdm_bclk/tdm_fsync/tdm_sdata go to 0, and the frame restarts at slot 0 if ENABLE is still 1.
  - A DATA push in the same cycle as a flush is lost, but still acked.
- Serialiser, ENABLE = 0: tdm_bclk, tdm_fsync and tdm_sdata are held at 0; the divider, bit, slot and FIFO contents are held.
- Serialiser, ENABLE = 1:
  - The divider toggles tdm_bclk every CLK_DIV cycles.
  - Outputs change only on BCLK falling edges. The first bit is presented in the cycle after ENABLE rises, i.e. before the first rising edge at CLK_DIV cycles.
- Frame timing:
  - Frame = CHANNELS × SLOT_BITS BCLKs.
  - tdm_fsync is high for exactly bit 0 of slot 0 (one BCLK period).
  - Each slot carries its sample MSB-first, left-justified, then SLOT_BITS−SAMPLE_W zero bits.
- Frame-atomic pop:
  - At the start of slot 0, if level ≥ CHANNELS the frame is valid, and one sample is popped at the start of each slot, channel 0 first.
  - Otherwise the whole frame transmits zeros, no pops occur, and UNDERFLOW is set. This prevents channel slip.
- If an UNDERFLOW set and a clear write coincide, set wins.
- Reset asserted mid-frame: outputs drop to 0 asynchronously and all state is cleared.

Test Plan:
- Reset, then a read of STATUS → ack exactly 1 cycle after stb; data 0x0004_0000 (EMPTY=1, level 0).
- Push 8 samples 0x000001..0x000008 (CHANNELS=8, CLK_DIV=4), write CTRL=1 → fsync high during the first BCLK period; slot k shows value k+1 as 24 bits MSB-first followed by 8 zeros; frame is 256 BCLKs = 2048 clk; level returns to 0.
- Push 7 samples, enable → the full frame is zeros, UNDERFLOW=1, level stays 7; push 1 more → the next frame is valid. Writing 0x1_0000 to STATUS clears UNDERFLOW.
- Push 64 samples → STATUS FULL=1, level 64; 65th DATA write → wb_err_o, level stays 64. Access to 0xC → err.
- Write FLUSH mid-slot 3 → level 0; serial outputs reset and the next frame starts at slot 0 with zero data and UNDERFLOW set.
- Deassert reset_reset_n mid-frame → tdm_bclk/tdm_fsync/tdm_sdata are 0 with no clock edge; after release, STATUS reads 0x0004_0000 and CTRL reads 0.
